pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard controller for the 5-stage IF/ID/EX/MEM/WB integer pipeline.
- Keeps a shadow scoreboard of the EX, MEM and WB slots (dest, regwrite, memread, sources).
- Produces forwarding selects, load-use/RAW stalls, branch flushes and a global memory-wait freeze, so the pipeline no longer executes dependent instructions with stale operands.
- Instantiated at pipeline top beside the stage modules; drives their stall/flush enables and the EX operand muxes.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: the shadow slot record
// kept for EX/MEM/WB, and the EX operand forwarding select encodings.
package pipe_hazard_ctrl_pkg;

    // Slot register fields are sized for the widest supported register file.
    localparam int SLOT_AW = 8;

    typedef logic [SLOT_AW-1:0] sreg_t;

    typedef struct packed {
        logic  valid;
        sreg_t dest;
        logic  regwrite;
        logic  memread;
        sreg_t rs;
        sreg_t rt;
        logic  use_rs;
        logic  use_rt;
    } slot_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic logic slot_writes(slot_t s, sreg_t r);
        return s.valid && s.regwrite && (s.dest == r) && (r != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_counter.sv
// Saturating event counter; holds while the pipeline is frozen and never wraps.
module hz_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) return v;
        return v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !freeze) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage integer pipeline: tracks EX/MEM/WB in a
// shadow scoreboard and drives stalls, flushes, freeze and EX forwarding.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int FORWARD_EN       = 1,
    parameter int RF_WRITE_THROUGH = 1,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              br_taken,
    input  logic              mem_wait,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    slot_t ex_s, mem_s, wb_s, id_s;
    logic  hz;

    // A source is hazardous when its producer cannot yet supply the value to EX.
    function automatic logic produces(slot_t ex, slot_t mem, slot_t wb, sreg_t r);
        if (FORWARD_EN != 0) return slot_writes(ex, r) && ex.memread;
        return slot_writes(ex, r) || slot_writes(mem, r) ||
               (slot_writes(wb, r) && (RF_WRITE_THROUGH == 0));
    endfunction

    // MEM is the youngest producer and wins; a load in MEM cannot be a source.
    function automatic logic [1:0] fwd_sel(slot_t mem, slot_t wb, sreg_t r, logic use_r);
        if ((FORWARD_EN == 0) || !use_r) return FWD_REG;
        if (slot_writes(mem, r) && !mem.memread) return FWD_MEM;
        if (slot_writes(wb, r)) return FWD_WB;
        return FWD_REG;
    endfunction

    always_comb begin
        id_s = '0;
        if (id_valid) begin
            id_s.valid    = 1'b1;
            id_s.dest     = SLOT_AW'(id_dest);
            id_s.regwrite = id_regwrite;
            id_s.memread  = id_memread;
            id_s.rs       = SLOT_AW'(id_rs);
            id_s.rt       = SLOT_AW'(id_rt);
            id_s.use_rs   = id_use_rs;
            id_s.use_rt   = id_use_rt;
        end
    end

    assign hz = id_valid &&
                ((id_use_rs && produces(ex_s, mem_s, wb_s, id_s.rs)) ||
                 (id_use_rt && produces(ex_s, mem_s, wb_s, id_s.rt)));

    // Priority: mem_wait > br_taken > hz; everything is quiet during reset.
    always_comb begin
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        freeze       = 1'b0;
        if (!reset) begin
            freeze = 1'b0;
        end else if (mem_wait) begin
            freeze = 1'b1;
        end else if (br_taken) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (hz) begin
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    // ID -> EX -> MEM -> WB shadow slot advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_s  <= '0;
            mem_s <= '0;
            wb_s  <= '0;
        end else if (!mem_wait) begin
            wb_s <= mem_s;
            if (br_taken) begin
                ex_s  <= '0;
                mem_s <= '0;
            end else if (hz) begin
                ex_s  <= '0;
                mem_s <= ex_s;
            end else begin
                ex_s  <= id_s;
                mem_s <= ex_s;
            end
        end
    end

    assign fwd_a_sel = fwd_sel(mem_s, wb_s, ex_s.rs, ex_s.use_rs);
    assign fwd_b_sel = fwd_sel(mem_s, wb_s, ex_s.rt, ex_s.use_rt);

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (stall_if_id),
        .freeze (mem_wait),
        .count  (stall_cnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (flush_if_id),
        .freeze (mem_wait),
        .count  (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding build and a stall-only build with a
// tiny counter share the same ID/control stimulus, each tracked by a model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       iv, urs, urt, rw, mr, br, mw;
    logic [4:0] rs, rt, dest;

    logic       a_st, a_bu, a_fi, a_fd, a_fe, a_fz;
    logic [1:0] a_fa, a_fb;
    logic [15:0] a_sc, a_fc;
    logic       b_st, b_bu, b_fi, b_fd, b_fe, b_fz;
    logic [1:0] b_fa, b_fb;
    logic [1:0] b_sc, b_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .FORWARD_EN(1), .RF_WRITE_THROUGH(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_valid(iv), .id_rs(rs), .id_rt(rt),
        .id_use_rs(urs), .id_use_rt(urt), .id_dest(dest), .id_regwrite(rw),
        .id_memread(mr), .br_taken(br), .mem_wait(mw),
        .stall_if_id(a_st), .bubble_id_ex(a_bu), .flush_if_id(a_fi),
        .flush_id_ex(a_fd), .flush_ex_mem(a_fe), .freeze(a_fz),
        .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .FORWARD_EN(0), .RF_WRITE_THROUGH(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .id_valid(iv), .id_rs(rs), .id_rt(rt),
        .id_use_rs(urs), .id_use_rt(urt), .id_dest(dest), .id_regwrite(rw),
        .id_memread(mr), .br_taken(br), .mem_wait(mw),
        .stall_if_id(b_st), .bubble_id_ex(b_bu), .flush_if_id(b_fi),
        .flush_id_ex(b_fd), .flush_ex_mem(b_fe), .freeze(b_fz),
        .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    // Reference model: each build is an in-flight instruction list [EX, MEM, WB].
    typedef struct {
        bit v;
        int dest;
        bit rw;
        bit mr;
        int rs;
        int rt;
        bit urs;
        bit urt;
    } ins_t;

    ins_t pipe [2][3];
    int   scnt [2];
    int   fcnt [2];

    function automatic bit fe(int k);   return k == 0; endfunction
    function automatic bit wt(int k);   return k == 0; endfunction
    function automatic int cmax(int k); return (k == 0) ? 65535 : 3; endfunction

    function automatic ins_t bubble();
        ins_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic ins_t cur_id();
        ins_t t;
        t = bubble();
        if (iv) begin
            t.v = 1; t.dest = int'(dest); t.rw = rw; t.mr = mr;
            t.rs = int'(rs); t.rt = int'(rt); t.urs = urs; t.urt = urt;
        end
        return t;
    endfunction

    function automatic bit wr(int k, int s, int r);
        return pipe[k][s].v && pipe[k][s].rw && (pipe[k][s].dest == r) && (r != 0);
    endfunction

    function automatic bit prodm(int k, int r);
        if (fe(k)) return wr(k, 0, r) && pipe[k][0].mr;
        return wr(k, 0, r) || wr(k, 1, r) || (wr(k, 2, r) && !wt(k));
    endfunction

    function automatic bit hzm(int k);
        return iv && ((urs && prodm(k, int'(rs))) || (urt && prodm(k, int'(rt))));
    endfunction

    function automatic logic [1:0] fwdm(int k, bit use_rt);
        int r;
        bit u;
        r = use_rt ? pipe[k][0].rt : pipe[k][0].rs;
        u = use_rt ? pipe[k][0].urt : pipe[k][0].urs;
        if (!fe(k) || !u) return 2'd0;
        if (wr(k, 1, r) && !pipe[k][1].mr) return 2'd1;
        if (wr(k, 2, r)) return 2'd2;
        return 2'd0;
    endfunction

    // Bit order: stall, bubble, flush_if_id, flush_id_ex, flush_ex_mem, freeze, fwd_a, fwd_b
    function automatic logic [9:0] expv(int k);
        logic [9:0] v;
        v = '0;
        if (mw)           v[4]   = 1'b1;
        else if (br)      v[7:5] = 3'b111;
        else if (hzm(k))  v[9:8] = 2'b11;
        v[3:2] = fwdm(k, 1'b0);
        v[1:0] = fwdm(k, 1'b1);
        return v;
    endfunction

    function automatic logic [9:0] obsv(int k);
        if (k == 0) return {a_st, a_bu, a_fi, a_fd, a_fe, a_fz, a_fa, a_fb};
        return {b_st, b_bu, b_fi, b_fd, b_fe, b_fz, b_fa, b_fb};
    endfunction

    function automatic logic [31:0] obs_sc(int k);
        return (k == 0) ? 32'(a_sc) : 32'(b_sc);
    endfunction

    function automatic logic [31:0] obs_fc(int k);
        return (k == 0) ? 32'(a_fc) : 32'(b_fc);
    endfunction

    task automatic advance(int k);
        bit h;
        h = hzm(k);
        if (mw) return;
        if (br) begin
            pipe[k][2] = pipe[k][1];
            pipe[k][1] = bubble();
            pipe[k][0] = bubble();
            if (fcnt[k] < cmax(k)) fcnt[k]++;
        end else if (h) begin
            pipe[k][2] = pipe[k][1];
            pipe[k][1] = pipe[k][0];
            pipe[k][0] = bubble();
            if (scnt[k] < cmax(k)) scnt[k]++;
        end else begin
            pipe[k][2] = pipe[k][1];
            pipe[k][1] = pipe[k][0];
            pipe[k][0] = cur_id();
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) pipe[k][s] = bubble();
            scnt[k] = 0;
            fcnt[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ctl%0d", k), 32'(obsv(k)), 32'(expv(k)));
            chk($sformatf("stall_cnt%0d", k), obs_sc(k), 32'(scnt[k]));
            chk($sformatf("flush_cnt%0d", k), obs_fc(k), 32'(fcnt[k]));
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_ctl%0d", tag, k), 32'(obsv(k)), 32'd0);
            chk($sformatf("%s_scnt%0d", tag, k), obs_sc(k), 32'd0);
            chk($sformatf("%s_fcnt%0d", tag, k), obs_fc(k), 32'd0);
        end
    endtask

    task automatic drv(input bit v_, input int d_, input int s_, input int t_,
                       input bit us_, input bit ut_, input bit w_, input bit m_,
                       input bit b_, input bit mw_);
        iv = v_; dest = 5'(d_); rs = 5'(s_); rt = 5'(t_);
        urs = us_; urt = ut_; rw = w_; mr = m_; br = b_; mw = mw_;
    endtask

    // Drive one ID/control cycle and check at the falling edge.
    task automatic half(input bit v_, input int d_, input int s_, input int t_,
                        input bit us_, input bit ut_, input bit w_, input bit m_,
                        input bit b_, input bit mw_);
        drv(v_, d_, s_, t_, us_, ut_, w_, m_, b_, mw_);
        @(negedge clk);
        check_all();
    endtask

    task automatic commit();
        for (int k = 0; k < 2; k++) advance(k);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        half(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        commit();
    endtask

    // Present an instruction until build k accepts it.
    task automatic issue(input int k, input int d_, input int s_, input int t_,
                         input bit us_, input bit ut_, input bit w_, input bit m_);
        bit done;
        bit h;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            half(1, d_, s_, t_, us_, ut_, w_, m_, 0, 0);
            h = hzm(k);
            commit();
            if (!h) done = 1;
        end
        if (!done) begin
            errors++;
            $error("FAIL issue_timeout build=%0d observed=stalled expected=accepted", k);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_zero("reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        bit stalled;
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ALU chain: add r3<-r1,r2 ; sub r4<-r3,r5
        issue(0, 3, 1, 2, 1, 1, 1, 0);
        issue(0, 4, 3, 5, 1, 1, 1, 0);
        half(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_fwd_a", 32'(a_fa), 32'd1);
        chk("alu_stall_cnt", 32'(a_sc), 32'd0);
        commit();
        repeat (3) nop();

        // One-instruction gap: add r3 ; nop ; or r6<-r3,r7
        issue(0, 3, 1, 2, 1, 1, 1, 0);
        nop();
        issue(0, 6, 3, 7, 1, 1, 1, 0);
        half(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("gap_fwd_a", 32'(a_fa), 32'd2);
        commit();

        // MEM and WB both write r3: MEM wins
        issue(0, 3, 1, 2, 1, 1, 1, 0);
        issue(0, 3, 1, 2, 1, 1, 1, 0);
        issue(0, 6, 3, 7, 1, 1, 1, 0);
        half(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("both_fwd_a", 32'(a_fa), 32'd1);
        commit();

        // Load-use: lw r8 ; add r9<-r8,r8
        do_reset();
        issue(0, 8, 1, 0, 1, 0, 1, 1);
        half(1, 9, 8, 8, 1, 1, 1, 0, 0, 0);
        chk("lu_stall", 32'({a_st, a_bu}), 32'd3);
        commit();
        half(1, 9, 8, 8, 1, 1, 1, 0, 0, 0);
        chk("lu_no_2nd_stall", 32'(a_st), 32'd0);
        commit();
        half(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_ab", 32'({a_fa, a_fb}), 32'hA);
        chk("lu_stall_cnt", 32'(a_sc), 32'd1);
        commit();

        // Load into r0 never stalls
        issue(0, 0, 1, 0, 1, 0, 1, 1);
        half(1, 9, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("r0_no_stall", 32'(a_st), 32'd0);
        commit();

        // Branch taken on top of a load-use hazard
        do_reset();
        issue(0, 8, 1, 0, 1, 0, 1, 1);
        half(1, 9, 8, 8, 1, 1, 1, 0, 1, 0);
        chk("br_flush3", 32'({a_fi, a_fd, a_fe}), 32'd7);
        chk("br_no_stall", 32'(a_st), 32'd0);
        commit();
        half(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_flush_cnt", 32'(a_fc), 32'd1);
        chk("br_stall_cnt", 32'(a_sc), 32'd0);
        commit();

        // mem_wait held 3 cycles over a load-use hazard
        do_reset();
        issue(0, 8, 1, 0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            half(1, 9, 8, 8, 1, 1, 1, 0, 0, 1);
            chk("mw_freeze", 32'({a_fz, a_st, a_fi}), 32'd4);
            chk("mw_cnt_hold", 32'(a_sc), 32'd0);
            commit();
        end
        half(1, 9, 8, 8, 1, 1, 1, 0, 0, 0);
        chk("mw_release_stall", 32'(a_st), 32'd1);
        commit();
        issue(0, 9, 8, 8, 1, 1, 1, 0);

        // Stall-only build: dependent directly behind producer
        do_reset();
        issue(1, 3, 1, 2, 1, 1, 1, 0);
        n = 0;
        stalled = 1;
        for (int i = 0; i < 8 && stalled; i++) begin
            half(1, 4, 3, 5, 1, 1, 1, 0, 0, 0);
            stalled = b_st;
            commit();
            if (stalled) n++;
        end
        chk("b_raw_stalls", 32'(n), 32'd3);
        chk("b_stall_cnt", 32'(b_sc), 32'd3);
        issue(1, 5, 4, 4, 1, 1, 1, 0);
        chk("b_stall_cnt_sat", 32'(b_sc), 32'd3);

        // Reset asserted mid-flush takes effect without a clock edge
        issue(0, 3, 1, 2, 1, 1, 1, 0);
        issue(0, 4, 3, 5, 1, 1, 1, 0);
        half(1, 6, 4, 3, 1, 1, 1, 0, 1, 0);
        chk("pre_rst_flush", 32'(a_fi), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        nop();

        // Randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            half($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
